bus_client_gen: RTL and testbench

- Parametrised, next-generation bus client (traffic generator) for the bus-arbiter testbed.
- Issues bursts of read or write requests to an address window, via an rq/ack handshake toward the arbiter.
- An internal LFSR randomises request timing and read/write mix.
- Adds over the first-generation client: configurable bursts, window wrap at an arbitrary base, read-data capture, transaction counters and an optional ack watchdog.

---
 rtl/bus_client_gen.sv | 158 +++++++++++++++
 tb/tb_bus_client_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bus_client_gen.sv
// bus_client_gen: LFSR-driven burst traffic generator for the bus-arbiter
// testbed. Issues read/write bursts over an address window through an rq/ack
// handshake, captures read data and counts completed beats.
// Optional build macro CLIENT_TIMEOUT_EN adds an ack watchdog that aborts a
// stalled burst and raises a sticky timeout_err.
module bus_client_gen #(
  parameter int unsigned DATA_WIDTH           = 8,
  parameter int unsigned ADDR_WIDTH           = 4,
  parameter int unsigned ADDR_SPACE_BEGINNING = 0,
  parameter int unsigned ADDR_SPACE_END       = 3,
  parameter int unsigned LFSR_WIDTH           = 5,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = 5'b00101,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = 5'b10100,
  parameter int unsigned BURST_LEN            = 4,
  parameter int unsigned TIMEOUT_CYCLES       = 16,
  parameter int unsigned CNT_WIDTH            = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  rq,
  input  logic                  ack,
  output logic                  wr_ni,
  output logic [DATA_WIDTH-1:0] dataW,
  input  logic [DATA_WIDTH-1:0] dataR,
  output logic [DATA_WIDTH-1:0] last_rdata,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic                  busy,
  output logic                  timeout_err
);

  // Reject configurations the datapath cannot honour.
  if (ADDR_SPACE_END < ADDR_SPACE_BEGINNING) begin : g_chk_window
    $error("bus_client_gen: ADDR_SPACE_END below ADDR_SPACE_BEGINNING");
  end
  if (LFSR_WIDTH < 2) begin : g_chk_lfsr
    $error("bus_client_gen: LFSR_WIDTH must be at least 2");
  end
  if (BURST_LEN < 1) begin : g_chk_burst
    $error("bus_client_gen: BURST_LEN must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("bus_client_gen: TIMEOUT_CYCLES must be at least 2");
  end

  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] A_BEGIN   = ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
  localparam logic [ADDR_WIDTH-1:0] A_END     = ADDR_WIDTH'(ADDR_SPACE_END);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [LFSR_WIDTH-1:0] SEED_EFF  =
    (LFSR_SEED == '0) ? LFSR_WIDTH'(1) : LFSR_SEED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [BEAT_W-1:0]     beat;
  logic                  lfsr_fb;

  assign lfsr_fb = ^(lfsr & LFSR_TAPS);

`ifdef CLIENT_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd;
  logic            timeout_q;

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Burst FSM with registered handshake outputs, beat datapath and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rq         <= 1'b0;
      busy       <= 1'b0;
      wr_ni      <= 1'b1;
      address    <= A_BEGIN;
      dataW      <= '0;
      last_rdata <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
      beat       <= '0;
      lfsr       <= SEED_EFF;
`ifdef CLIENT_TIMEOUT_EN
      wd         <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          lfsr <= {lfsr[LFSR_WIDTH-2:0], lfsr_fb};
          if (enable && lfsr[0]) begin
            state <= REQ;
            rq    <= 1'b1;
            busy  <= 1'b1;
            wr_ni <= lfsr[1];
            beat  <= '0;
`ifdef CLIENT_TIMEOUT_EN
            wd    <= '0;
`endif
          end
        end
        REQ: begin
          if (ack) begin
`ifdef CLIENT_TIMEOUT_EN
            wd <= '0;
`endif
            if (wr_ni) begin
              last_rdata <= dataR;
              rd_count   <= rd_count + CNT_WIDTH'(1);
            end else begin
              wr_count <= wr_count + CNT_WIDTH'(1);
              dataW    <= dataW + DATA_WIDTH'(1);
            end
            address <= (address == A_END) ? A_BEGIN : address + ADDR_WIDTH'(1);
            if (beat == BEAT_LAST) begin
              state <= GAP;
              rq    <= 1'b0;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
`ifdef CLIENT_TIMEOUT_EN
          // Abort leaves address, data and counters untouched.
          else if (wd == WD_LAST) begin
            state     <= GAP;
            rq        <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wd <= wd + WD_W'(1);
          end
`endif
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          rq    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_client_gen.sv
// Directed self-checking bench for bus_client_gen. Instance A uses default
// parameters (seed 5'b00101 starts with a write burst); instance B uses a
// window 2..5, 5-beat bursts and seed 5'b00011 (starts with a read burst).
module tb_bus_client_gen;

  logic       clk = 1'b0;
  int         errors = 0;
  int         checks = 0;

  // Instance A signals
  logic       rst_a = 1'b1, en_a = 1'b0, ack_a = 1'b0;
  logic [7:0] dataR_a = '0;
  logic [3:0] address_a;
  logic       rq_a, wr_ni_a, busy_a, tmo_a;
  logic [7:0] dataW_a, last_rdata_a;
  logic [15:0] rd_count_a, wr_count_a;

  // Instance B signals
  logic       rst_b = 1'b1, en_b = 1'b0, ack_b = 1'b0;
  logic [7:0] dataR_b = '0;
  logic [3:0] address_b;
  logic       rq_b, wr_ni_b, busy_b, tmo_b;
  logic [7:0] dataW_b, last_rdata_b;
  logic [15:0] rd_count_b, wr_count_b;

  always #5 clk = ~clk;

  bus_client_gen dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .address(address_a), .rq(rq_a),
    .ack(ack_a), .wr_ni(wr_ni_a), .dataW(dataW_a), .dataR(dataR_a),
    .last_rdata(last_rdata_a), .rd_count(rd_count_a), .wr_count(wr_count_a),
    .busy(busy_a), .timeout_err(tmo_a)
  );

  bus_client_gen #(
    .ADDR_SPACE_BEGINNING(2),
    .ADDR_SPACE_END(5),
    .BURST_LEN(5),
    .LFSR_SEED(5'b00011)
  ) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .address(address_b), .rq(rq_b),
    .ack(ack_b), .wr_ni(wr_ni_b), .dataW(dataW_b), .dataR(dataR_b),
    .last_rdata(last_rdata_b), .rd_count(rd_count_b), .wr_count(wr_count_b),
    .busy(busy_b), .timeout_err(tmo_b)
  );

  task automatic reset_a(input logic en);
    rst_a = 1'b1; en_a = en;
    @(posedge clk); #1;
    rst_a = 1'b0;
  endtask

  task automatic reset_b(input logic en);
    rst_b = 1'b1; en_b = en;
    @(posedge clk); #1;
    rst_b = 1'b0;
  endtask

  task automatic test_reset;
    ack_a = 1'b1; dataR_a = 8'h3C;
    reset_a(1'b0);
    checks++; if (rq_a !== 1'b0) begin errors++; $display("FAIL rst_rq: got %b want 0", rq_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_a); end
    checks++; if (wr_ni_a !== 1'b1) begin errors++; $display("FAIL rst_wr_ni: got %b want 1", wr_ni_a); end
    checks++; if (address_a !== 4'd0) begin errors++; $display("FAIL rst_address: got %0d want 0", address_a); end
    checks++; if (dataW_a !== 8'h00) begin errors++; $display("FAIL rst_dataW: got %0h want 0", dataW_a); end
    checks++; if (last_rdata_a !== 8'h00) begin errors++; $display("FAIL rst_last_rdata: got %0h want 0", last_rdata_a); end
    checks++; if (rd_count_a !== 16'd0) begin errors++; $display("FAIL rst_rd_count: got %0d want 0", rd_count_a); end
    checks++; if (wr_count_a !== 16'd0) begin errors++; $display("FAIL rst_wr_count: got %0d want 0", wr_count_a); end
    checks++; if (tmo_a !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", tmo_a); end
    // ack while rq is low must be ignored
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (rq_a !== 1'b0) begin errors++; $display("FAIL idle_rq: got %b want 0", rq_a); end
    checks++; if (rd_count_a !== 16'd0 || wr_count_a !== 16'd0) begin errors++; $display("FAIL idle_ack_ignored: rd=%0d wr=%0d want 0/0", rd_count_a, wr_count_a); end
    checks++; if (address_a !== 4'd0) begin errors++; $display("FAIL idle_address: got %0d want 0", address_a); end
  endtask

  task automatic test_write_burst;
    ack_a = 1'b1;
    reset_a(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (rq_a !== 1'b1) begin errors++; $display("FAIL wr_rq beat%0d: got %b want 1", i, rq_a); end
      checks++; if (address_a !== 4'(i)) begin errors++; $display("FAIL wr_address beat%0d: got %0d want %0d", i, address_a, i); end
      checks++; if (dataW_a !== 8'(i)) begin errors++; $display("FAIL wr_dataW beat%0d: got %0h want %0h", i, dataW_a, i); end
      checks++; if (wr_ni_a !== 1'b0) begin errors++; $display("FAIL wr_wr_ni beat%0d: got %b want 0", i, wr_ni_a); end
    end
    @(posedge clk); #1;
    checks++; if (rq_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL wr_gap: rq=%b busy=%b want 0/1", rq_a, busy_a); end
    checks++; if (wr_count_a !== 16'd4) begin errors++; $display("FAIL wr_count: got %0d want 4", wr_count_a); end
    checks++; if (dataW_a !== 8'h04) begin errors++; $display("FAIL wr_dataW_end: got %0h want 4", dataW_a); end
    checks++; if (address_a !== 4'd0) begin errors++; $display("FAIL wr_address_wrap: got %0d want 0", address_a); end
    @(posedge clk); #1;
    checks++; if (rq_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL wr_idle: rq=%b busy=%b want 0/0", rq_a, busy_a); end
    // LFSR 00101 -> 01011 after the first IDLE cycle: next burst is a read
    @(posedge clk); #1;
    checks++; if (rq_a !== 1'b1 || wr_ni_a !== 1'b1) begin errors++; $display("FAIL lfsr_next_burst: rq=%b wr_ni=%b want 1/1", rq_a, wr_ni_a); end
  endtask

  task automatic test_reset_mid_burst;
    dataR_a = 8'h5A;
    reset_a(1'b0);
    checks++; if (rq_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL midrst_rq_busy: rq=%b busy=%b want 0/0", rq_a, busy_a); end
    checks++; if (rd_count_a !== 16'd0 || last_rdata_a !== 8'h00) begin errors++; $display("FAIL midrst_no_capture: rd=%0d last=%0h want 0/0", rd_count_a, last_rdata_a); end
    checks++; if (wr_count_a !== 16'd0 || dataW_a !== 8'h00 || address_a !== 4'd0) begin errors++; $display("FAIL midrst_clear: wr=%0d dataW=%0h addr=%0d want 0/0/0", wr_count_a, dataW_a, address_a); end
  endtask

  task automatic test_enable_drop;
    int cnt;
    ack_a = 1'b1;
    reset_a(1'b1);
    cnt = 0;
    @(posedge clk); #1; cnt += int'(rq_a);
    @(posedge clk); #1; cnt += int'(rq_a);
    en_a = 1'b0;
    checks++; if (rq_a !== 1'b1) begin errors++; $display("FAIL endrop_continue: rq=%b want 1", rq_a); end
    repeat (30) begin @(posedge clk); #1; cnt += int'(rq_a); end
    checks++; if (cnt !== 4) begin errors++; $display("FAIL endrop_rq_cycles: got %0d want 4", cnt); end
    checks++; if (wr_count_a !== 16'd4) begin errors++; $display("FAIL endrop_wr_count: got %0d want 4", wr_count_a); end
    checks++; if (busy_a !== 1'b0 || rq_a !== 1'b0) begin errors++; $display("FAIL endrop_idle: busy=%b rq=%b want 0/0", busy_a, rq_a); end
  endtask

  task automatic test_window_stall;
    logic [3:0] exp_addr [0:4];
    logic [7:0] rdat [0:4];
    exp_addr[0] = 4'd2; exp_addr[1] = 4'd3; exp_addr[2] = 4'd4; exp_addr[3] = 4'd5; exp_addr[4] = 4'd2;
    rdat[0] = 8'hA5; rdat[1] = 8'h11; rdat[2] = 8'h22; rdat[3] = 8'h33; rdat[4] = 8'h44;
    ack_b = 1'b0;
    reset_b(1'b1);
    checks++; if (address_b !== 4'd2) begin errors++; $display("FAIL b_rst_address: got %0d want 2", address_b); end
    @(posedge clk); #1;
    en_b = 1'b0;
    checks++; if (rq_b !== 1'b1 || wr_ni_b !== 1'b1) begin errors++; $display("FAIL b_start_read: rq=%b wr_ni=%b want 1/1", rq_b, wr_ni_b); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (rq_b !== 1'b1 || address_b !== 4'd2 || wr_ni_b !== 1'b1) begin errors++; $display("FAIL b_stall%0d: rq=%b addr=%0d wr_ni=%b want 1/2/1", i, rq_b, address_b, wr_ni_b); end
      checks++; if (rd_count_b !== 16'd0) begin errors++; $display("FAIL b_stall_count%0d: got %0d want 0", i, rd_count_b); end
    end
    ack_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rq_b !== 1'b1 || address_b !== exp_addr[k]) begin errors++; $display("FAIL b_window beat%0d: rq=%b addr=%0d want 1/%0d", k, rq_b, address_b, exp_addr[k]); end
      dataR_b = rdat[k];
      @(posedge clk); #1;
      if (k == 0) begin
        checks++; if (last_rdata_b !== 8'hA5 || rd_count_b !== 16'd1) begin errors++; $display("FAIL b_capture: last=%0h rd=%0d want a5/1", last_rdata_b, rd_count_b); end
      end
    end
    checks++; if (rq_b !== 1'b0 || busy_b !== 1'b1) begin errors++; $display("FAIL b_gap: rq=%b busy=%b want 0/1", rq_b, busy_b); end
    checks++; if (rd_count_b !== 16'd5 || last_rdata_b !== 8'h44) begin errors++; $display("FAIL b_end: rd=%0d last=%0h want 5/44", rd_count_b, last_rdata_b); end
    checks++; if (address_b !== 4'd3 || wr_count_b !== 16'd0 || dataW_b !== 8'h00) begin errors++; $display("FAIL b_end_addr: addr=%0d wr=%0d dataW=%0h want 3/0/0", address_b, wr_count_b, dataW_b); end
  endtask

  task automatic test_watchdog;
    int cnt;
    int exp_cnt;
    logic exp_tmo;
`ifdef CLIENT_TIMEOUT_EN
    exp_cnt = 16; exp_tmo = 1'b1;
`else
    exp_cnt = 40; exp_tmo = 1'b0;
`endif
    ack_a = 1'b0;
    reset_a(1'b1);
    @(posedge clk); #1;
    en_a = 1'b0;
    checks++; if (rq_a !== 1'b1) begin errors++; $display("FAIL wd_start: rq=%b want 1", rq_a); end
    cnt = 1;
    repeat (39) begin @(posedge clk); #1; cnt += int'(rq_a); end
    checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL wd_rq_cycles: got %0d want %0d", cnt, exp_cnt); end
    checks++; if (tmo_a !== exp_tmo) begin errors++; $display("FAIL wd_timeout_err: got %b want %b", tmo_a, exp_tmo); end
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (tmo_a !== exp_tmo) begin errors++; $display("FAIL wd_sticky: got %b want %b", tmo_a, exp_tmo); end
    checks++; if (wr_count_a !== 16'd0 || rd_count_a !== 16'd0) begin errors++; $display("FAIL wd_counts: rd=%0d wr=%0d want 0/0", rd_count_a, wr_count_a); end
    checks++; if (address_a !== 4'd0 || dataW_a !== 8'h00) begin errors++; $display("FAIL wd_no_advance: addr=%0d dataW=%0h want 0/0", address_a, dataW_a); end
    reset_a(1'b0);
    checks++; if (tmo_a !== 1'b0 || rq_a !== 1'b0) begin errors++; $display("FAIL wd_reset_clear: tmo=%b rq=%b want 0/0", tmo_a, rq_a); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_write_burst();
    test_reset_mid_burst();
    test_enable_drop();
    test_window_stall();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
